// File: rtl/twiddle_rot_w8_pkg.sv
// Shared definitions for the radix-8 twiddle rotator: index encoding, the
// conjugate remap, and the fixed-point 1/sqrt(2) multiplier constant.
package twiddle_rot_w8_pkg;

  typedef logic [2:0] tw_idx_t;

  typedef enum logic [2:0] {
    TW_K0 = 3'd0,
    TW_K1 = 3'd1,
    TW_K2 = 3'd2,
    TW_K3 = 3'd3,
    TW_K4 = 3'd4,
    TW_K5 = 3'd5,
    TW_K6 = 3'd6,
    TW_K7 = 3'd7
  } tw_idx_e;

  // conj(W8^k) == W8^((8-k) mod 8)
  function automatic tw_idx_t k_prime(input tw_idx_t k, input logic inv);
    return inv ? tw_idx_t'(3'd0 - k) : k;
  endfunction

  // round(2^(w-1)/sqrt(2)) == round(sqrt(2^(2w-3))), valid for w <= 31
  function automatic longint unsigned twiddle_c(input int w);
    longint unsigned n;
    longint unsigned r;
    longint unsigned t;
    n = 64'd1 << (2 * w - 3);
    r = 64'd0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    if ((4 * r * r + 4 * r + 1) < (4 * n)) r = r + 64'd1;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_rot_w8_if.sv
// Input/output streaming bundle of the twiddle rotator.
interface twiddle_rot_w8_if
  import twiddle_rot_w8_pkg::*;
#(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  tw_idx_t      in_k;
  logic         inverse;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         out_ovf;

  modport master (
    output in_valid, in_re, in_im, in_k, inverse, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_ovf
  );

  modport slave (
    input  in_valid, in_re, in_im, in_k, inverse, out_ready,
    output in_ready, out_valid, out_re, out_im, out_ovf
  );
endinterface

// File: rtl/twiddle_rot_w8_sat_round.sv
// Optional round-half-up, arithmetic right shift, then reduction to W bits
// with clamp or wrap; ovf_o flags any value that did not fit.
module twiddle_sat_round #(
  parameter int IW    = 33,
  parameter int W     = 16,
  parameter int SHIFT = 15,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [IW-1:0] x_i,
  output logic signed [W-1:0]  y_o,
  output logic                 ovf_o
);

  localparam logic signed [IW:0] ONE  = 1;
  localparam logic signed [IW:0] BIAS = (ROUND != 0) ? (ONE <<< (SHIFT - 1)) : '0;

  logic signed [IW:0] sum;
  logic signed [IW:0] shr;
  logic               in_range;

  always_comb begin
    sum      = {x_i[IW-1], x_i} + BIAS;
    shr      = sum >>> SHIFT;
    in_range = (&shr[IW:W-1]) || !(|shr[IW:W-1]);
    ovf_o    = !in_range;
    y_o      = shr[W-1:0];
    if (!in_range && (SAT != 0)) begin
      y_o = shr[IW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/twiddle_rot_w8.sv
// Three-stage complex rotator by W8^k (optionally conjugated) with
// valid/ready flow control: S1 add/negate/swap, S2 scale, S3 round+reduce.
module twiddle_rot_w8
  import twiddle_rot_w8_pkg::*;
#(
  parameter int W     = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  twiddle_rot_w8_if.slave  bus
);

  localparam int                     PW    = 2 * W + 1;
  localparam longint unsigned        C_VAL = twiddle_c(W);
  localparam logic signed [PW-1:0]   C_X   = PW'(C_VAL);

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic rdy1, rdy2, rdy3;

  // Each stage accepts when empty or when its contents move on this cycle
  assign rdy3 = !v3_q || bus.out_ready;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;
  assign v1_d = rdy1 ? bus.in_valid : v1_q;
  assign v2_d = rdy2 ? v1_q : v2_q;
  assign v3_d = rdy3 ? v2_q : v3_q;
  assign bus.in_ready = rdy1;

  logic signed [W:0] a_x, b_x;
  logic signed [W:0] s1_re_d, s1_im_d, s1_re_q, s1_im_q;
  logic              s1_odd_q;
  tw_idx_t           kp;

  always_comb begin
    a_x     = {bus.in_re[W-1], bus.in_re};
    b_x     = {bus.in_im[W-1], bus.in_im};
    kp      = k_prime(bus.in_k, bus.inverse);
    s1_re_d = a_x;
    s1_im_d = b_x;
    case (kp)
      TW_K0: begin s1_re_d = a_x;        s1_im_d = b_x;        end
      TW_K1: begin s1_re_d = a_x + b_x;  s1_im_d = b_x - a_x;  end
      TW_K2: begin s1_re_d = b_x;        s1_im_d = -a_x;       end
      TW_K3: begin s1_re_d = b_x - a_x;  s1_im_d = -a_x - b_x; end
      TW_K4: begin s1_re_d = -a_x;       s1_im_d = -b_x;       end
      TW_K5: begin s1_re_d = -a_x - b_x; s1_im_d = a_x - b_x;  end
      TW_K6: begin s1_re_d = -b_x;       s1_im_d = a_x;        end
      TW_K7: begin s1_re_d = a_x - b_x;  s1_im_d = a_x + b_x;  end
      default: ;
    endcase
  end

  logic signed [PW-1:0] re_x, im_x;
  logic signed [PW-1:0] p_re_d, p_im_d, p_re_q, p_im_q;

  // Even twiddles are pre-shifted so S3 applies one uniform shift; the
  // rounding bias then falls entirely in discarded zero bits.
  always_comb begin
    re_x   = {{W{s1_re_q[W]}}, s1_re_q};
    im_x   = {{W{s1_im_q[W]}}, s1_im_q};
    p_re_d = s1_odd_q ? (re_x * C_X) : (re_x <<< (W - 1));
    p_im_d = s1_odd_q ? (im_x * C_X) : (im_x <<< (W - 1));
  end

  logic signed [W-1:0] y_re, y_im;
  logic                ovf_re, ovf_im;

  twiddle_sat_round #(.IW(PW), .W(W), .SHIFT(W - 1), .ROUND(ROUND), .SAT(SAT)) u_sr_re (
    .x_i   (p_re_q),
    .y_o   (y_re),
    .ovf_o (ovf_re)
  );

  twiddle_sat_round #(.IW(PW), .W(W), .SHIFT(W - 1), .ROUND(ROUND), .SAT(SAT)) u_sr_im (
    .x_i   (p_im_q),
    .y_o   (y_im),
    .ovf_o (ovf_im)
  );

  logic signed [W-1:0] out_re_q, out_im_q;
  logic                out_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_odd_q  <= 1'b0;
      p_re_q    <= '0;
      p_im_q    <= '0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (rdy1 && bus.in_valid) begin
        s1_re_q  <= s1_re_d;
        s1_im_q  <= s1_im_d;
        s1_odd_q <= kp[0];
      end
      if (rdy2 && v1_q) begin
        p_re_q <= p_re_d;
        p_im_q <= p_im_d;
      end
      if (rdy3 && v2_q) begin
        out_re_q  <= y_re;
        out_im_q  <= y_im;
        out_ovf_q <= ovf_re || ovf_im;
      end
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_twiddle_rot_w8.sv
// Directed-vector bench for twiddle_rot_w8 (W=16, ROUND=1, SAT=1).
module tb_twiddle_rot_w8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  twiddle_rot_w8_if #(.W(16)) bus ();

  twiddle_rot_w8 #(.W(16), .ROUND(1), .SAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int re; int im; int k; int inv;
    int ere; int eim; int eovf;
  } vec_t;

  vec_t tbl[20];

  task automatic init_table();
    // plain rotations, including one that rounds up from 0.707
    tbl[0]  = '{1000, 0, 1, 0, 707, -707, 0};
    tbl[1]  = '{100, -50, 2, 0, -50, -100, 0};
    tbl[2]  = '{100, -50, 0, 0, 100, -50, 0};
    tbl[3]  = '{100, -50, 6, 0, 50, 100, 0};
    tbl[4]  = '{100, -50, 4, 0, -100, 50, 0};
    tbl[5]  = '{1000, 0, 3, 0, -707, -707, 0};
    tbl[6]  = '{1000, 0, 5, 0, -707, 707, 0};
    tbl[7]  = '{1000, 0, 7, 0, 707, 707, 0};
    tbl[8]  = '{1, 0, 1, 0, 1, -1, 0};
    // saturation boundaries
    tbl[9]  = '{-32768, 0, 4, 0, 32767, 0, 1};
    tbl[10] = '{32767, 32767, 1, 0, 32767, 0, 1};
    tbl[11] = '{-32768, -32768, 1, 0, -32768, 0, 1};
    tbl[12] = '{-32768, 5, 2, 0, 5, 32767, 1};
    tbl[13] = '{32767, -32768, 6, 0, 32767, 32767, 1};
    tbl[14] = '{32767, 0, 4, 0, -32767, 0, 0};
    // conjugate mode
    tbl[15] = '{1000, 0, 7, 1, 707, -707, 0};
    tbl[16] = '{100, -50, 0, 1, 100, -50, 0};
    tbl[17] = '{100, -50, 2, 1, 50, 100, 0};
    tbl[18] = '{1000, 0, 1, 1, 707, 707, 0};
    tbl[19] = '{-32768, 0, 4, 1, 32767, 0, 1};
  endtask

  task automatic send_one(input int re, input int im, input int k, input int inv,
                          output logic signed [15:0] ore, output logic signed [15:0] oim,
                          output logic oovf, output int lat, output logic rdy);
    bus.in_valid  = 1'b1;
    bus.in_re     = 16'(re);
    bus.in_im     = 16'(im);
    bus.in_k      = 3'(k);
    bus.inverse   = inv[0];
    bus.out_ready = 1'b1;
    #1;
    rdy = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    ore  = bus.out_re;
    oim  = bus.out_im;
    oovf = bus.out_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_k      = '0;
    bus.inverse   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_re !== 16'd0 || bus.out_im !== 16'd0 || bus.out_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b re=%0d im=%0d ovf=%b, expected all 0",
               bus.out_valid, bus.out_re, bus.out_im, bus.out_ovf);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_table(input string name, input int lo, input int hi);
    logic signed [15:0] ore, oim, ere, eim;
    logic oovf, rdy;
    int lat;
    for (int i = lo; i <= hi; i++) begin
      send_one(tbl[i].re, tbl[i].im, tbl[i].k, tbl[i].inv, ore, oim, oovf, lat, rdy);
      ere = 16'(tbl[i].ere);
      eim = 16'(tbl[i].eim);
      n_cmp++;
      if (rdy !== 1'b1) begin
        n_err++;
        $display("FAIL %s[%0d] in_ready: got %b expected 1", name, i, rdy);
      end
      n_cmp++;
      if (lat !== 3) begin
        n_err++;
        $display("FAIL %s[%0d] latency: got %0d expected 3", name, i, lat);
      end
      n_cmp++;
      if (ore !== ere || oim !== eim || oovf !== tbl[i].eovf[0]) begin
        n_err++;
        $display("FAIL %s[%0d] value: got re=%0d im=%0d ovf=%b, expected re=%0d im=%0d ovf=%b",
                 name, i, ore, oim, oovf, ere, eim, tbl[i].eovf[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_re[8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    int exp_im[8] = '{0, -707, -1000, -707, 0, 707, 1000, 707};
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic in_fire, out_fire;
    while (out_idx < 8 && cyc < 60) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 8);
      bus.in_valid  = (in_idx < 8);
      bus.in_re     = 16'd1000;
      bus.in_im     = 16'd0;
      bus.in_k      = 3'(in_idx);
      bus.inverse   = 1'b0;
      #1;
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      if (cyc <= 3) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream_b2b_ready cyc%0d: got %b expected 1", cyc, bus.in_ready);
        end
      end
      if (cyc == 8) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || (in_idx - out_idx) !== 3) begin
          n_err++;
          $display("FAIL stream_stall_hold: got in_ready=%b out_valid=%b held=%0d, expected 0 1 3",
                   bus.in_ready, bus.out_valid, in_idx - out_idx);
        end
      end
      if (out_fire) begin
        n_cmp++;
        if (out_idx >= 8) begin
          n_err++;
          $display("FAIL stream_extra: got output #%0d expected only 8", out_idx);
        end else if ($signed(bus.out_re) !== 16'(exp_re[out_idx]) ||
                     $signed(bus.out_im) !== 16'(exp_im[out_idx]) || bus.out_ovf !== 1'b0) begin
          n_err++;
          $display("FAIL stream_out[%0d]: got re=%0d im=%0d ovf=%b, expected re=%0d im=%0d ovf=0",
                   out_idx, $signed(bus.out_re), $signed(bus.out_im), bus.out_ovf,
                   exp_re[out_idx], exp_im[out_idx]);
        end
        out_idx++;
      end
      if (in_fire) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (out_idx !== 8 || in_idx !== 8) begin
      n_err++;
      $display("FAIL stream_count: got in=%0d out=%0d expected 8 8", in_idx, out_idx);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_dup: got out_valid=%b after drain expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_flush();
    logic signed [15:0] ore, oim;
    logic oovf, rdy;
    int lat;
    int seen = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_re     = 16'd500;
    bus.in_im     = 16'd0;
    bus.in_k      = 3'd0;
    bus.inverse   = 1'b0;
    @(posedge clk); #1;
    bus.in_re = 16'd600;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre_valid: got %b expected 1", bus.out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_re !== 16'd0) begin
      n_err++;
      $display("FAIL flush_out_valid: got v=%b re=%0d expected 0 0", bus.out_valid, bus.out_re);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL flush_discard: got %0d stale outputs expected 0", seen);
    end
    send_one(300, -200, 2, 0, ore, oim, oovf, lat, rdy);
    n_cmp++;
    if (lat !== 3 || ore !== -16'sd200 || oim !== -16'sd300 || oovf !== 1'b0) begin
      n_err++;
      $display("FAIL flush_next: got lat=%0d re=%0d im=%0d ovf=%b, expected lat=3 re=-200 im=-300 ovf=0",
               lat, ore, oim, oovf);
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_table("rotate", 0, 8);
    test_table("saturate", 9, 14);
    test_table("inverse", 15, 19);
    test_backpressure();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
